mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 109 ++++++++++
 tb/tb_mult_div_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit.
//   clk, reset (async, active-low), start/op/a/b request an operation,
//   hi_wr/lo_wr/wdata implement mthi/mtlo, busy flags an operation in flight,
//   hi/lo are the architectural HI/LO registers.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BPC  = (32 + DIV_CYCLES - 1) / DIV_CYCLES;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d, sa_q, sa_d, sb_q, sb_d;
  logic [31:0]   x_q, x_d, y_q, y_d, r_q, r_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0]    n_q, n_d;
  logic [63:0]   prod;
  logic [32:0]   t;
  logic          ge, sgn;
  assign busy = cnt_q != '0;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign sgn  = ~op[0];
  // Operands are held as magnitudes; the sign is reapplied at the end.
  assign prod = {32'b0, x_q} * {32'b0, y_q};
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    x_d   = x_q;
    y_d   = y_q;
    r_d   = r_q;
    n_d   = n_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    t     = '0;
    ge    = 1'b0;
    if (start && !busy) begin
      cnt_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      div_d = op[1];
      sa_d  = sgn & a[31];
      sb_d  = sgn & b[31];
      x_d   = sa_d ? -a : a;
      y_d   = sb_d ? -b : b;
      r_d   = '0;
      n_d   = 6'd32;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      // Restoring division, BPC quotient bits per cycle; x shifts out the
      // dividend and shifts in the quotient.
      if (div_q)
        for (int i = 0; i < BPC; i++)
          if (n_d != '0) begin
            t   = {r_d, x_d[31]};
            ge  = t >= {1'b0, y_q};
            x_d = {x_d[30:0], ge};
            r_d = ge ? t[31:0] - y_q : t[31:0];
            n_d = n_d - 1'b1;
          end
      if (cnt_q == CW'(1)) begin
        if (!div_q) {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod : prod;
        else if (y_q != '0) begin
          lo_d = (sa_q ^ sb_q) ? -x_d : x_d;
          hi_d = sa_q ? -r_d : r_d;
        end
      end
    end else begin
      hi_d = hi_wr ? wdata : hi_q;
      lo_d = lo_wr ? wdata : lo_q;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      r_q   <= '0;
      n_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      x_q   <= x_d;
      y_q   <= y_d;
      r_q   <= r_d;
      n_q   <= n_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed check of mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  logic        clk = 0, reset = 0, start = 0, hi_wr = 0, lo_wr = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic        busy;
  logic [31:0] hi, lo;
  int          total = 0, bad = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;
  always #5 clk = ~clk;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint n, d;
    logic [63:0] p;
    case (o)
      2'd0: begin p = longint'($signed(x)) * longint'($signed(y)); {exp_hi, exp_lo} = p; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; {exp_hi, exp_lo} = p; end
      2'd2: if (y != 0) begin
        n = longint'($signed(x));
        d = longint'($signed(y));
        exp_lo = 32'(n / d);
        exp_hi = 32'(n % d);
      end
      default: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
    endcase
  endtask
  task automatic wait_idle(input int n, input string tag);
    int c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, c, n);
  endtask
  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic w, input string tag);
    start = 1; op = o; a = x; b = y; hi_wr = w; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 0; hi_wr = 0; a = $urandom; b = $urandom; op = 2'($urandom);
    model(o, x, y);
    wait_idle(o[1] ? 10 : 5, {tag, "_lat"});
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic w, input string tag);
    @(negedge clk);
    go(o, x, y, w, tag);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    start = 1; op = 2'd1; a = 5; b = 7;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1; start = 0;
    run(2'd0, 32'hFFFF_FFFE, 32'd3, 0, "mult_neg");
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run(2'd3, 32'd7, 32'd0, 0, "divu_zero");
    check("divz_hi_kept", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1; op = 2'd0; a = 6; b = 7;
    @(posedge clk); #1;
    start = 0;
    model(2'd0, 6, 7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 3); op = 2'd2; hi_wr = start; wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      check("ign_busy", 32'(busy), 32'(k < 5));
    end
    start = 0; hi_wr = 0;
    check("ign_hi", hi, 0);
    check("ign_lo", lo, 42);
    @(negedge clk);
    lo_wr = 1; wdata = 32'h1234;
    @(posedge clk); #1;
    lo_wr = 0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi", hi, 0);
    @(negedge clk);
    start = 1; op = 2'd2; a = 100; b = 7;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    exp_hi = 0; exp_lo = 0;
    @(negedge clk);
    reset = 1;
    go(2'd0, 32'd2, 32'd3, 0, "post_rst");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run(2'd0, 32'h0001_0000, 32'h0003_0000, 1, "start_hiwr");
    @(negedge clk);
    hi_wr = 1; lo_wr = 1; wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    hi_wr = 0; lo_wr = 0;
    check("mt_both_hi", hi, 32'hA5A5_5A5A);
    check("mt_both_lo", lo, 32'hA5A5_5A5A);
    exp_hi = hi_tb_const(); exp_lo = 32'hA5A5_5A5A;
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o;
      logic [31:0] x, y;
      o = 2'($urandom);
      x = pick();
      y = pick();
      run(o, x, y, 1'($urandom), $sformatf("rnd%0d_op%0d", i, o));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        hi_wr = 1'($urandom); lo_wr = 1'($urandom); wdata = $urandom;
        if (hi_wr) exp_hi = wdata;
        if (lo_wr) exp_lo = wdata;
        @(posedge clk); #1;
        hi_wr = 0; lo_wr = 0;
        check("rnd_mt_hi", hi, exp_hi);
        check("rnd_mt_lo", lo, exp_lo);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  function automatic logic [31:0] hi_tb_const();
    return 32'hA5A5_5A5A;
  endfunction
endmodule
